// File: rtl/router_switch_allocator_if.sv
// rtl/router_switch_allocator_if.sv - request, flow-control and crossbar signals of the switch allocator
interface router_switch_allocator_if;
   logic [4:0]       req_i;
   logic [4:0][2:0]  dest_i;
   logic [4:0]       flit_valid_i;
   logic [4:0]       tail_i;
   logic [4:0]       credit_i;
   logic [4:0][2:0]  sel_o;
   logic [4:0]       lock_o;
   logic [4:0]       tx_o;
   logic [4:0]       fwd_o;

   modport master (
      output req_i, dest_i, flit_valid_i, tail_i, credit_i,
      input  sel_o, lock_o, tx_o, fwd_o
   );

   modport slave (
      input  req_i, dest_i, flit_valid_i, tail_i, credit_i,
      output sel_o, lock_o, tx_o, fwd_o
   );
endinterface

// File: rtl/router_switch_allocator.sv
// rtl/router_switch_allocator.sv - round-robin wormhole switch allocator with per-output credit tracking
module router_switch_allocator #(
   parameter int NPORT        = 5,
   parameter int BUFFER_DEPTH = 16,
   parameter int CNT_WIDTH    = 5
) (
   input logic                      clock,
   input logic                      reset,
   router_switch_allocator_if.slave bus
);

   typedef enum logic {S_IDLE, S_LOCKED} state_t;

   state_t               state_q [NPORT];
   state_t               state_d [NPORT];
   logic [2:0]           sel_q   [NPORT];
   logic [2:0]           sel_d   [NPORT];
   logic [2:0]           ptr_q   [NPORT];
   logic [2:0]           ptr_d   [NPORT];
   logic [CNT_WIDTH-1:0] cred_q  [NPORT];
   logic [CNT_WIDTH-1:0] cred_d  [NPORT];

   logic [NPORT-1:0]     in_busy;
   logic [NPORT-1:0]     cand    [NPORT];
   logic [NPORT-1:0]     grant_vld;
   logic [2:0]           grant_idx [NPORT];
   logic [NPORT-1:0]     tx;
   logic [NPORT-1:0]     tail_own;
   logic [NPORT-1:0]     fwd;
   logic [NPORT-1:0][2:0] sel_flat;

   localparam logic [CNT_WIDTH-1:0] CRED_MAX = CNT_WIDTH'(BUFFER_DEPTH);

   // Inputs currently owning some output are excluded from new arbitration
   always_comb begin
      in_busy = '0;
      for (int o = 0; o < NPORT; o++) begin
         for (int i = 0; i < NPORT; i++) begin
            if (state_q[o] == S_LOCKED && sel_q[o] == 3'(i)) begin
               in_busy[i] = 1'b1;
            end
         end
      end
   end

   // Candidate matrix and round-robin pick starting at each output's pointer
   always_comb begin
      for (int o = 0; o < NPORT; o++) begin
         cand[o]      = '0;
         grant_vld[o] = 1'b0;
         grant_idx[o] = 3'd0;
         for (int i = 0; i < NPORT; i++) begin
            cand[o][i] = bus.req_i[i] && (bus.dest_i[i] == 3'(o)) && (i != o) && !in_busy[i];
         end
         for (int k = 0; k < NPORT; k++) begin
            int idx;
            idx = int'(ptr_q[o]) + k;
            if (idx >= NPORT) begin
               idx = idx - NPORT;
            end
            for (int i = 0; i < NPORT; i++) begin
               if (!grant_vld[o] && idx == i && cand[o][i]) begin
                  grant_vld[o] = 1'b1;
                  grant_idx[o] = 3'(i);
               end
            end
         end
      end
   end

   // Transfer strobes: owner has a flit and the downstream buffer has room
   always_comb begin
      tx       = '0;
      tail_own = '0;
      fwd      = '0;
      for (int o = 0; o < NPORT; o++) begin
         for (int i = 0; i < NPORT; i++) begin
            if (state_q[o] == S_LOCKED && sel_q[o] == 3'(i)) begin
               tx[o]       = bus.flit_valid_i[i] && (cred_q[o] != '0);
               tail_own[o] = bus.tail_i[i];
            end
         end
         for (int i = 0; i < NPORT; i++) begin
            if (tx[o] && sel_q[o] == 3'(i)) begin
               fwd[i] = 1'b1;
            end
         end
      end
   end

   // Per-output FSM next state, owner select, round-robin pointer and credits
   always_comb begin
      for (int o = 0; o < NPORT; o++) begin
         state_d[o] = state_q[o];
         sel_d[o]   = sel_q[o];
         ptr_d[o]   = ptr_q[o];
         cred_d[o]  = cred_q[o];
         case (state_q[o])
            S_IDLE: begin
               if (grant_vld[o]) begin
                  state_d[o] = S_LOCKED;
                  sel_d[o]   = grant_idx[o];
               end
            end
            S_LOCKED: begin
               if (tx[o] && tail_own[o]) begin
                  state_d[o] = S_IDLE;
                  ptr_d[o]   = (sel_q[o] == 3'(NPORT - 1)) ? 3'd0 : sel_q[o] + 3'd1;
               end
            end
            default: state_d[o] = S_IDLE;
         endcase
         // A credit arriving with a transfer cancels out; extra credits at full are dropped
         if (bus.credit_i[o] && !tx[o] && cred_q[o] != CRED_MAX) begin
            cred_d[o] = cred_q[o] + 1'b1;
         end else if (!bus.credit_i[o] && tx[o]) begin
            cred_d[o] = cred_q[o] - 1'b1;
         end
      end
   end

   // State registers with synchronous reset dropping every lock
   always_ff @(posedge clock) begin
      for (int o = 0; o < NPORT; o++) begin
         if (reset) begin
            state_q[o] <= S_IDLE;
            sel_q[o]   <= 3'd0;
            ptr_q[o]   <= 3'd0;
            cred_q[o]  <= CRED_MAX;
         end else begin
            state_q[o] <= state_d[o];
            sel_q[o]   <= sel_d[o];
            ptr_q[o]   <= ptr_d[o];
            cred_q[o]  <= cred_d[o];
         end
      end
   end

   // Output drive; combinational strobes are held low while reset is asserted
   always_comb begin
      for (int o = 0; o < NPORT; o++) begin
         sel_flat[o] = sel_q[o];
      end
   end

   assign bus.sel_o  = sel_flat;
   assign bus.tx_o   = tx & {NPORT{~reset}};
   assign bus.fwd_o  = fwd & {NPORT{~reset}};

   // Lock status follows the registered FSM state
   always_comb begin
      bus.lock_o = '0;
      for (int o = 0; o < NPORT; o++) begin
         bus.lock_o[o] = (state_q[o] == S_LOCKED) && !reset;
      end
   end

endmodule

// File: doc/router_switch_allocator.md
Name: router_switch_allocator

Overview:
Per-router switch allocator and output flow-control controller for the 5-port wormhole router (ports 0=EAST, 1=WEST, 2=NORTH, 3=SOUTH, 4=LOCAL).
- Input buffers present head-flit requests with a routed destination port.
- The block arbitrates each output round-robin and locks the output to the winning input until that input's tail flit passes.
- It tracks downstream credits per output and drives crossbar selects, per-output tx strobes and per-input buffer pop strobes.

Parameters:
- NPORT, 5, number of router ports; fixed at 5, and the 3-bit port codes depend on it.
- BUFFER_DEPTH, 16, downstream buffer slots per output; this is the initial and maximum credit count.
- CNT_WIDTH, 5, credit counter width; must satisfy 2^CNT_WIDTH > BUFFER_DEPTH.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_i  input  [4:0]  per input: head of buffer belongs to a packet requesting an output.
- dest_i  input  [4:0][2:0]  per input: requested output port code (0..4); sampled only while req_i is high.
- flit_valid_i  input  [4:0]  per input: a flit is present at the buffer head.
- tail_i  input  [4:0]  per input: the head flit is the last flit of its packet.
- credit_i  input  [4:0]  per output: one-cycle pulse, one downstream slot freed.
- sel_o  output  [4:0][2:0]  per output: crossbar source input index.
- lock_o  output  [4:0]  per output: output is allocated to an input.
- tx_o  output  [4:0]  per output: a flit is transferred on this output this cycle.
- fwd_o  output  [4:0]  per input: pop strobe, the head flit is consumed this cycle.

Behaviour:
Reset:
- Every output FSM goes to IDLE.
- rr_ptr[o] = 0, credit_cnt[o] = BUFFER_DEPTH, sel_o = 0.
- lock_o = 0, tx_o = 0, fwd_o = 0 (combinational outputs are forced 0 while reset is high).
- A reset mid-packet drops all locks immediately; the partially sent packet is abandoned and the allocator does not recover it.

Per-output FSM (one instance per output o):
- IDLE:
  - Candidates are inputs i with req_i[i]=1, dest_i[i]==o, i!=o (no U-turn), and i not locked to any output.
  - Search order starts at rr_ptr[o] and ascends modulo 5; the first candidate wins.
  - On a win: next state LOCKED, owner[o]=i, sel_o[o]=i, lock_o[o]=1, all at the next edge.
  - No candidate: stay in IDLE.
- LOCKED:
  - tx_o[o] = flit_valid_i[owner] & (credit_cnt[o]!=0), combinational from registered state.
  - fwd_o[owner] = tx_o[o].
  - On tx with tail_i[owner]=1: next state IDLE, lock_o[o]=0, rr_ptr[o]=(owner+1) mod 5.
- Latency: request at cycle N gives lock at N+1. The first flit can transfer in cycle N+1 if credit is available.
- Conflicts: an input requests only one output, so at most one output grants a given input. fwd_o is the OR over outputs, and at most one output is owned by a given input.
- While LOCKED, the owner's req_i and dest_i are ignored; only flit_valid_i and tail_i matter.

Credits:
- credit_cnt[o] next value = credit_cnt + credit_i[o] - tx_o[o].
- A simultaneous credit and tx leaves the count unchanged.
- The count saturates at BUFFER_DEPTH; an excess credit is ignored.
- A count of 0 blocks tx; the lock is held.

Illegal inputs:
- dest_i > 4: never granted, request ignored.
- dest_i == own index: never granted.
- flit_valid_i=0 while LOCKED: stall, lock held, no tx.

Test Plan:
- Single request: input 4 requests output 0 at cycle 1 with a 3-flit packet whose last flit is the tail. Required: lock_o[0]=1 and sel_o[0]=4 at cycle 2; tx_o[0] and fwd_o[4] high in cycles 2-4; lock_o[0]=0 at cycle 5; rr_ptr[0]=0.
- Contention: inputs 1, 2 and 3 all request output 0 in the same cycle, each with a 1-flit packet. Required: grant order 1, 2, 3 in cycles 2, 4 and 6, since each release plus re-arbitration takes 2 cycles.
- Credit exhaustion: BUFFER_DEPTH=16 and an endless packet from input 0 to output 2 with no credit_i. Required: 16 tx pulses, then tx_o[2]=0 with the lock held. A single credit_i[2] pulse yields exactly one further tx on the following cycle.
- Simultaneous credit and tx: at count 5, credit_i and tx coincide. Required: count stays 5. At count 16, a credit without tx leaves the count at 16.
- Reset mid-packet: output 1 locked to input 3 with 2 flits sent, then reset held for 1 cycle. Required: lock_o=0, tx_o=0, credit_cnt=16 on the next cycle. A new request from input 0 is granted 1 cycle after reset deasserts.
- Illegal destinations: input 2 requests dest 2, and input 0 requests dest 6. Required: no lock_o or fwd_o activity for 20 cycles.
